sklansky_sad_unit: RTL and testbench

Parametrised, pipelined sum-of-absolute-differences (SAD) engine built on a generic-width Sklansky parallel-prefix adder. It accepts one pair of samples per cycle over a valid/ready handshake, computes |a − b| and accumulates it over a fixed block of BLOCK_LEN samples. It presents one SAD result per block on a valid/ready output port. It is the next-generation datapath behind the 8-bit registered prefix adder and sits between the sample source and the block-matching logic.

---
 rtl/sklansky_sad_unit.sv | 190 +++++++++++++++++++
 tb/tb_sklansky_sad_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_sad_unit.sv
// rtl/sklansky_sad_unit.sv - pipelined sum-of-absolute-differences engine on Sklansky prefix adders
//
// Optional build macro: SKLANSKY_SAD_SIGNED_EN (two's complement samples; unsigned when undefined)
//
// sklansky_sad_unit_adder ports:
//    x, y      N-bit addends
//    cin       carry in
//    sum       N-bit sum (carry out discarded)
//
// sklansky_sad_unit ports:
//    clock     rising-edge clock
//    reset_n   synchronous active-low reset
//    clear     synchronous flush of the partial block
//    in_valid  sample pair valid
//    in_ready  unit can accept a sample pair
//    a, b      WIDTH-bit samples
//    out_valid sad holds a completed block result
//    out_ready consumer accepts the result
//    sad       ACC_W-bit block result

module sklansky_sad_unit_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic [N-1:0] sum
);
   localparam int LV = $clog2(N);

   logic [N-1:0] hp;
   logic [N-1:0] carry;

   assign hp = x ^ y;

   // Each level holds group generate/propagate spanning back from bit i; level LV
   // gives the carry out of bits [i:0] with cin folded into bit 0's generate.
   for (genvar l = 0; l <= LV; l++) begin : lv
      logic [N-1:0] gg;
      logic [N-1:0] pp;
      if (l == 0) begin : base
         assign gg = (x & y) | {{(N-1){1'b0}}, hp[0] & cin};
         assign pp = hp;
      end else begin : comb
         for (genvar i = 0; i < N; i++) begin : bitc
            if (((i >> (l - 1)) & 1) == 1) begin : blk
               // Combine with the top bit of the preceding 2^(l-1) block.
               localparam int J = ((i >> (l - 1)) << (l - 1)) - 1;
               assign gg[i] = lv[l-1].gg[i] | (lv[l-1].pp[i] & lv[l-1].gg[J]);
               assign pp[i] = lv[l-1].pp[i] & lv[l-1].pp[J];
            end else begin : pass
               assign gg[i] = lv[l-1].gg[i];
               assign pp[i] = lv[l-1].pp[i];
            end
         end
      end
   end

   assign carry = {lv[LV].gg[N-2:0], cin};
   assign sum   = hp ^ carry;
endmodule

module sklansky_sad_unit #(
   parameter int WIDTH     = 8,
   parameter int BLOCK_LEN = 16
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic                                  clear,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [WIDTH-1:0]                      a,
   input  logic [WIDTH-1:0]                      b,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [WIDTH+$clog2(BLOCK_LEN)-1:0]    sad
);
   localparam int ACC_W = WIDTH + $clog2(BLOCK_LEN);
   localparam int CNT_W = $clog2(BLOCK_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   logic             stall;
   logic             accept;
   logic [WIDTH:0]   ax;
   logic [WIDTH:0]   bx;
   logic [WIDTH:0]   d_ab;
   logic [WIDTH:0]   d_ba;
   logic [WIDTH-1:0] abs_diff;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_last;

   logic [WIDTH-1:0] s1_abs;
   logic             s1_valid;
   logic             s1_last;

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall & ~clear;
   assign accept   = in_valid & in_ready;

`ifdef SKLANSKY_SAD_SIGNED_EN
   assign ax = {a[WIDTH-1], a};
   assign bx = {b[WIDTH-1], b};
`else
   assign ax = {1'b0, a};
   assign bx = {1'b0, b};
`endif

   // Subtraction as x + ~y + 1; one extra bit makes d_ab[WIDTH] the borrow/sign
   // in both signed and unsigned modes.
   sklansky_sad_unit_adder #(.N(WIDTH + 1)) u_ab (
      .x   (ax),
      .y   (~bx),
      .cin (1'b1),
      .sum (d_ab)
   );

   sklansky_sad_unit_adder #(.N(WIDTH + 1)) u_ba (
      .x   (bx),
      .y   (~ax),
      .cin (1'b1),
      .sum (d_ba)
   );

   assign abs_diff = d_ab[WIDTH] ? d_ba[WIDTH-1:0] : d_ab[WIDTH-1:0];

   sklansky_sad_unit_adder #(.N(CNT_W)) u_cnt (
      .x   (cnt),
      .y   ({CNT_W{1'b0}}),
      .cin (1'b1),
      .sum (cnt_inc)
   );

   assign cnt_last = (cnt == CNT_LAST);

   sklansky_sad_unit_adder #(.N(ACC_W)) u_acc (
      .x   (acc),
      .y   ({{(ACC_W-WIDTH){1'b0}}, s1_abs}),
      .cin (1'b0),
      .sum (acc_sum)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt       <= '0;
         s1_abs    <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         acc       <= '0;
         sad       <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         cnt      <= '0;
         s1_valid <= 1'b0;
         acc      <= '0;
         // The output handshake still completes during a flush.
         if (out_ready) begin
            out_valid <= 1'b0;
         end
      end else begin
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         // A completed block written here overrides the drop above.
         if (s1_valid && !stall) begin
            if (s1_last) begin
               sad       <= acc_sum;
               out_valid <= 1'b1;
               acc       <= '0;
            end else begin
               acc <= acc_sum;
            end
         end
         if (!stall) begin
            if (accept) begin
               s1_abs   <= abs_diff;
               s1_valid <= 1'b1;
               s1_last  <= cnt_last;
               cnt      <= cnt_last ? '0 : cnt_inc;
            end else begin
               s1_valid <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_sklansky_sad_unit.sv
// tb/tb_sklansky_sad_unit.sv - self-checking bench for sklansky_sad_unit
module tb_sklansky_sad_unit;
   localparam int WIDTH     = 8;
   localparam int BLOCK_LEN = 4;
   localparam int ACC_W     = 10;

   logic             clock;
   logic             reset_n;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] sad;

   int tests;
   int failed;

   int part_sum;
   int part_cnt;
   int exp_q[$];

   logic             held;
   logic [ACC_W-1:0] held_sad;
   logic             last_ov;
   logic [ACC_W-1:0] last_sad;
   logic             saw_stall;

   sklansky_sad_unit #(.WIDTH(WIDTH), .BLOCK_LEN(BLOCK_LEN)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sad       (sad)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int absdiff(input logic [7:0] x, input logic [7:0] y);
      int sx;
      int sy;
`ifdef SKLANSKY_SAD_SIGNED_EN
      sx = int'($signed(x));
      sy = int'($signed(y));
`else
      sx = int'(x);
      sy = int'(y);
`endif
      return (sx > sy) ? sx - sy : sy - sx;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive at negedge, sample settled outputs, update the model,
   // then wait for the active edge.
   task automatic cycle(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic orr, input logic clr, output logic accepted);
      @(negedge clock);
      in_valid  = v;
      a         = ia;
      b         = ib;
      out_ready = orr;
      clear     = clr;
      #1;
      check("in_ready", in_ready, !(out_valid && !orr) && !clr);
      if (held) begin
         check("hold_valid", out_valid, 1);
         check("hold_sad", sad, held_sad);
      end
      held     = out_valid && !orr;
      held_sad = sad;
      last_ov  = out_valid;
      last_sad = sad;
      if (out_valid && !orr) saw_stall = 1'b1;
      if (out_valid && orr) begin
         check("result_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("sad", sad, exp_q.pop_front());
      end
      accepted = v && in_ready;
      if (accepted) begin
         part_sum += absdiff(ia, ib);
         part_cnt++;
         if (part_cnt == BLOCK_LEN) begin
            exp_q.push_back(part_sum);
            part_sum = 0;
            part_cnt = 0;
         end
      end
      if (clr) begin
         part_sum = 0;
         part_cnt = 0;
      end
      @(posedge clock);
   endtask

   task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic orr);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         cycle(1'b1, ia, ib, orr, 1'b0, acc);
         n++;
      end
      check("send_timeout", acc, 1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         idle(1);
         n++;
      end
      idle(2);
      check("drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_sad", sad, 0);
      check("rst_in_ready", in_ready, 1);
      exp_q.delete();
      part_sum = 0;
      part_cnt = 0;
      held     = 1'b0;
   endtask

   initial begin
      logic acc;
      logic [7:0] ra;
      logic [7:0] rb;
      logic rv;
      logic ro;
      logic rc;
      tests = 0;
      failed = 0;
      part_sum = 0;
      part_cnt = 0;
      held = 1'b0;
      saw_stall = 1'b0;
      reset_n = 1'b0;
      clear = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      repeat (2) @(posedge clock);
      do_reset();

      // Basic block with latency and throughput checks.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'd10, 8'd3, 1'b1, 1'b0, acc);
         check("basic_accept", acc, 1);
      end
      idle(1);
      check("lat_edge_k", last_ov, 0);
      idle(1);
      check("lat_edge_k1_valid", last_ov, 1);
      check("lat_edge_k1_sad", last_sad, 28);
      idle(1);
      check("pulse_one_cycle", last_ov, 0);
      drain();

`ifdef SKLANSKY_SAD_SIGNED_EN
      for (int i = 0; i < 4; i++) send(8'h80, 8'h7F, 1'b1);
      for (int i = 0; i < 4; i++) send(8'hFF, 8'h01, 1'b1);
      drain();
`else
      for (int i = 0; i < 4; i++) send(8'd0, 8'd255, 1'b1);
      idle(2);
      check("max_sad", last_sad, 1020);
      for (int i = 0; i < 2; i++) begin
         send(8'd255, 8'd0, 1'b1);
         send(8'd0, 8'd255, 1'b1);
      end
      drain();
`endif

      // Back-pressure: two blocks with the consumer stalled.
      saw_stall = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i + 1), 8'd0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'd9, 8'd2, 1'b0, 1'b0, acc);
      check("bp_stall_seen", saw_stall, 1);
      check("bp_in_ready_low", in_ready, 0);
      for (int i = part_cnt; i < 4; i++) send(8'd9, 8'd2, 1'b1);
      drain();

      // Clear after two samples discards the partial block.
      send(8'd50, 8'd0, 1'b1);
      send(8'd60, 8'd0, 1'b1);
      cycle(1'b1, 8'd70, 8'd0, 1'b1, 1'b1, acc);
      check("clear_no_accept", acc, 0);
      for (int i = 0; i < 4; i++) send(8'd5, 8'd1, 1'b1);
      idle(2);
      check("clear_sad", last_sad, 16);
      drain();

      // Reset mid-block.
      send(8'd100, 8'd0, 1'b1);
      send(8'd100, 8'd0, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) send(8'd1, 8'd2, 1'b1);
      idle(2);
      check("post_reset_sad", last_sad, 4);
      drain();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         ro = ($urandom_range(0, 3) != 0);
         rc = (part_cnt > 0) && ($urandom_range(0, 24) == 0);
         cycle(rv, ra, rb, ro, rc, acc);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
